// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small circular byte FIFO.
// Start, data and stop bits share one bit timer; a pop in STOP chains frames without an idle gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_TICK = 651,
  parameter int OVERSAMPLE    = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          CLK100MHZ,
  input  logic                          SWITCH_RESET,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_busy,
  output logic                          o_tx_done,
  output logic                          TX_OUTPUT
);

  localparam int BIT_CLKS = CLKS_PER_TICK * OVERSAMPLE;
  localparam int TW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_CLKS - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_next;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;
  logic [TW-1:0]   r_timer, w_timer_next;
  logic [7:0]      r_shift, w_shift_next;
  logic [2:0]      r_bit_idx, w_bit_idx_next;
  logic            w_tx_next, w_done_next;
  logic            w_push, w_pop, w_bit_end, w_fifo_empty;

  assign w_fifo_empty = (r_count == '0);
  assign o_ready      = (r_count != COUNT_FULL);
  assign w_push       = i_valid && o_ready;
  assign w_bit_end    = (r_timer == TIMER_LAST);
  assign o_fifo_count = r_count;
  assign o_busy       = (r_state != S_IDLE) || !w_fifo_empty;

  // Storage carries no reset; only pointers and count define the contents.
  always_ff @(posedge CLK100MHZ) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge CLK100MHZ or negedge SWITCH_RESET) begin
    if (!SWITCH_RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge SWITCH_RESET) begin
    if (!SWITCH_RESET) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_shift   <= '0;
      r_bit_idx <= '0;
      TX_OUTPUT <= 1'b1;
      o_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      TX_OUTPUT <= w_tx_next;
      o_tx_done <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_state_next = S_START;
          w_pop        = 1'b1;
        end
      end
      S_START: if (w_bit_end) w_state_next = S_DATA;
      S_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
      S_STOP: begin
        if (w_bit_end) begin
          if (!w_fifo_empty) begin
            w_state_next = S_START;
            w_pop        = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_next      = TX_OUTPUT;
    w_done_next    = 1'b0;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_timer_next   = (r_state == S_IDLE) ? '0 : r_timer + 1'b1;
    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (w_pop) begin
          w_shift_next = r_mem[r_rd_ptr];
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_timer_next   = '0;
          w_tx_next      = r_shift[0];
          w_bit_idx_next = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_timer_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_tx_next = 1'b1;
          end else begin
            w_tx_next      = r_shift[1];
            w_shift_next   = r_shift >> 1;
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_timer_next = '0;
          w_done_next  = 1'b1;
          if (w_pop) begin
            w_shift_next = r_mem[r_rd_ptr];
            w_tx_next    = 1'b0;
          end else begin
            w_tx_next = 1'b1;
          end
        end
      end
      default: w_tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized scoreboard bench for uart_tx_fifo: a timing model predicts every output each cycle,
// and a line decoder matches received frames against the bytes accepted into the FIFO.
module tb_uart_tx_fifo;
  localparam int CPT   = 2;
  localparam int OS    = 16;
  localparam int DEPTH = 4;
  localparam int BIT   = CPT * OS;
  localparam int FRAME = BIT * 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready, o_busy, o_tx_done, tx;
  logic [2:0] o_fifo_count;

  uart_tx_fifo #(.CLKS_PER_TICK(CPT), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
    .CLK100MHZ(clk), .SWITCH_RESET(rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_fifo_count(o_fifo_count), .o_busy(o_busy),
    .o_tx_done(o_tx_done), .TX_OUTPUT(tx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a byte queue plus the number of clocks left in the current frame.
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  int         frame_left = 0;
  logic [7:0] cur_byte = 8'h00;
  logic       m_done = 1'b0;
  bit         m_pop, m_acc;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      exp_q.delete();
      frame_left = 0;
      m_done = 1'b0;
    end else begin
      m_pop  = (m_q.size() > 0) && (frame_left <= 1);
      m_acc  = i_valid && (m_q.size() < DEPTH);
      m_done = (frame_left == 1);
      if (m_pop) begin
        cur_byte   = m_q.pop_front();
        frame_left = FRAME;
      end else if (frame_left > 0) begin
        frame_left--;
      end
      if (m_acc) begin
        m_q.push_back(i_data);
        exp_q.push_back(i_data);
      end
    end
  end

  function automatic logic exp_line();
    int e, b;
    if (frame_left == 0) return 1'b1;
    e = FRAME - frame_left;
    b = e / BIT;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur_byte[b-1];
    return 1'b1;
  endfunction

  // Cycle monitor: all outputs against the model, sampled mid-cycle.
  logic [6:0] exp_vec, act_vec;
  always @(negedge clk) begin
    exp_vec = {exp_line(), m_done, 3'(m_q.size()), (m_q.size() < DEPTH),
               ((frame_left > 0) || (m_q.size() > 0))};
    act_vec = {tx, o_tx_done, o_fifo_count, o_ready, o_busy};
    check("cycle_outputs{tx,done,count,ready,busy}", 32'(act_vec), 32'(exp_vec));
  end

  // Line decoder: samples the middle of each bit and pops the scoreboard on each stop bit.
  bit         dec_active = 0;
  int         dec_cnt = 0;
  int         dec_idx;
  int         frames = 0;
  logic [7:0] dec_byte = 8'h00;
  logic [7:0] dec_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      dec_active = 0;
    end else if (!dec_active) begin
      if (tx == 1'b0) begin
        dec_active = 1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt % BIT == BIT / 2) begin
        dec_idx = dec_cnt / BIT;
        if (dec_idx == 0) begin
          check("start_bit", 32'(tx), 32'd0);
        end else if (dec_idx <= 8) begin
          dec_byte[dec_idx-1] = tx;
        end else begin
          check("stop_bit", 32'(tx), 32'd1);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: got %02h expected no frame", dec_byte);
          end else begin
            dec_exp = exp_q.pop_front();
            frames++;
            if (dec_byte !== dec_exp) begin
              errors++;
              $display("FAIL frame_data: got %02h expected %02h", dec_byte, dec_exp);
            end else begin
              $display("frame %0d: byte %02h received", frames, dec_byte);
            end
          end
          dec_active = 0;
        end
      end
    end
  end

  bit track_peak = 0;
  int peak = 0;
  always @(negedge clk) if (track_peak && int'(o_fifo_count) > peak) peak = int'(o_fifo_count);

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((o_busy || exp_q.size() > 0 || dec_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic wait_done(output int edge_no);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_tx_done && k < 2000);
    checks++;
    if (k >= 2000) begin
      errors++;
      $display("FAIL done_timeout: got no o_tx_done expected a pulse");
    end
    edge_no = cyc;
  endtask

  int n_edge, d_edge;
  int d_edges[3];
  int k;

  initial begin
    // Reset and idle
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_ready", 32'(o_ready), 32'd1);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_count", 32'(o_fifo_count), 32'd0);

    // Single byte and done latency
    @(negedge clk); i_valid = 1'b1; i_data = 8'hA5;
    @(posedge clk); #1 n_edge = cyc;
    @(negedge clk); i_valid = 1'b0;
    wait_done(d_edge);
    check("done_latency", 32'(d_edge - n_edge), 32'd321);
    wait_idle(1000);
    check("single_busy_after", 32'(o_busy), 32'd0);

    // Back-to-back frames
    track_peak = 1; peak = 0;
    @(negedge clk); i_valid = 1'b1; i_data = 8'h00;
    @(negedge clk); i_data = 8'hFF;
    @(negedge clk); i_data = 8'h55;
    @(negedge clk); i_valid = 1'b0;
    for (int i = 0; i < 3; i++) wait_done(d_edges[i]);
    track_peak = 0;
    check("b2b_peak_count", 32'(peak), 32'd2);
    check("b2b_gap1", 32'(d_edges[1] - d_edges[0]), 32'(FRAME));
    check("b2b_gap2", 32'(d_edges[2] - d_edges[1]), 32'(FRAME));
    wait_idle(2000);

    // Full FIFO: sixth push is dropped
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 6) begin
        check("full_ready", 32'(o_ready), 32'd0);
        check("full_count", 32'(o_fifo_count), 32'd4);
      end
      i_valid = 1'b1; i_data = 8'(i);
    end
    @(negedge clk); i_valid = 1'b0;
    wait_idle(3000);

    // Push coinciding with the STOP->START pop
    @(negedge clk); i_valid = 1'b1; i_data = 8'h11;
    @(negedge clk); i_data = 8'h22;
    @(negedge clk); i_valid = 1'b0;
    k = 0;
    while (!(frame_left == 1 && m_q.size() == 1) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    i_valid = 1'b1; i_data = 8'h33;
    @(posedge clk); #1 check("simul_count", 32'(o_fifo_count), 32'd1);
    @(negedge clk); i_valid = 1'b0;
    wait_idle(2000);

    // Reset during data bit 3 with a byte still buffered
    @(negedge clk); i_valid = 1'b1; i_data = 8'h00;
    @(negedge clk); i_data = 8'h77;
    @(negedge clk); i_valid = 1'b0;
    k = 0;
    while (frame_left != FRAME - (4 * BIT + 10) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("tx_low_before_reset", 32'(tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("reset_tx_async", 32'(tx), 32'd1);
    check("reset_count_async", 32'(o_fifo_count), 32'd0);
    check("reset_busy_async", 32'(o_busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    check("post_reset_line", 32'(tx), 32'd1);
    @(negedge clk); i_valid = 1'b1; i_data = 8'h3C;
    @(negedge clk); i_valid = 1'b0;
    wait_idle(1000);

    // Random traffic, including drops while full
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      i_valid = ($urandom_range(0, 99) < 4);
      i_data  = 8'($urandom);
    end
    @(negedge clk); i_valid = 1'b0;
    wait_idle(8000);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
